pht_update_queue: RTL and testbench
===================================

Name: pht_update_queue

Overview:
- Sits directly downstream of the branch-resolution path and upstream of the gshare PHT write port.
- Consumes one resolved branch result per cycle and computes the new 2-bit saturating counter value.
- Buffers each update in a FIFO of write entries and drains one entry per cycle into the PHT whenever the fetch stage is not using the shared PHT port.
- Decouples execute-stage writes from fetch-stage PHT reads, so fetch never stalls.

Parameters:
QUEUE_SIZE, 32, FIFO depth in entries; must be a power of two.
PHT_ENTRY_NUM, 2048, PHT entry count; index width PHT_IW = log2(PHT_ENTRY_NUM).
GHIST_WIDTH, 10, global history width; must be <= PHT_IW.
PC_WIDTH, 32, program counter width.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
brValid  in  1  branch result valid this cycle
brAddr  in  PC_WIDTH  address of the resolved branch
brExecTaken  in  1  actual direction
brIsCondBr  in  1  branch is conditional
brGlobalHistory  in  GHIST_WIDTH  history captured at prediction time
brPhtPrevValue  in  2  PHT counter value read at prediction time
phtReadEn  in  1  fetch stage owns the PHT port this cycle
phtWE  out  1  PHT write enable
phtWA  out  PHT_IW  PHT write index
phtWV  out  2  PHT write value
queueFull  out  1  count == QUEUE_SIZE
queueCount  out  log2(QUEUE_SIZE)+1  current occupancy
dropPulse  out  1  an update was discarded this cycle

Behaviour:
- Reset, asynchronous on rst high: head = tail = 0, count = 0, dropPulse = 0. Combinationally phtWE = 0; phtWA and phtWV are don't-care.
- Eligibility: brValid && brIsCondBr. Non-conditional and invalid results are ignored.
- New counter value:
  - taken: new = (prev == 3) ? 3 : prev + 1
  - not taken: new = (prev == 0) ? 0 : prev - 1
  - If new == prev (saturated), nothing is enqueued and no drop is signalled.
- Index: phtWA = brAddr[PHT_IW+1:2] XOR (brGlobalHistory << (PHT_IW - GHIST_WIDTH)), result truncated to PHT_IW bits.
- Enqueue: an eligible, changing update is written at tail on the rising edge. tail wraps modulo QUEUE_SIZE.
- Dequeue:
  - doDeq = (count != 0) && !phtReadEn.
  - phtWE = doDeq, combinational; phtWA and phtWV come from the head entry.
  - head advances on the edge and wraps modulo QUEUE_SIZE.
- Latency: minimum 1 cycle from brValid to phtWE. There is no same-cycle bypass.
- Full handling:
  - If count == QUEUE_SIZE and doDeq is 0, an incoming enqueue is dropped: dropPulse = 1 registered for the next cycle, contents unchanged.
  - If full and doDeq is 1 in the same cycle, the enqueue is accepted and count stays QUEUE_SIZE.
- Simultaneous enqueue and dequeue with count == 0: no dequeue occurs (empty). The entry lands and count becomes 1.
- count update: count + enq - deq, where enq is the accepted enqueue (not the dropped one). count is never above QUEUE_SIZE and never below 0.
- Ordering: strict FIFO. Duplicate indices are not coalesced; the later write wins in the PHT.
- A reset asserted mid-drain discards all queued entries immediately. phtWE drops in the same cycle as rst rises.

Decomposition:
- Shared fetch-unit types package holds:
  - PhtQueueEntry {index PHT_IW, value 2 bits}
  - PhtQueuePointerPath
  - PHT_QUEUE_SIZE
  - the gshare index-hash function ToPHT_IndexByGShare(pc, history)
  - the saturating-counter function
- Natural sub-module: pht_update_fifo. It is a generic circular buffer with head/tail/count, full/empty and simultaneous push/pop handling, and it is reusable for a BTB update queue.
- The top level holds eligibility, hash, counter update and drop logic.

Test Plan:
- Basic update: reset, then brValid=1, brIsCondBr=1, brAddr=0x00001008, brGlobalHistory=0x155, prev=1, taken=1, phtReadEn=0. Next cycle phtWE=1, phtWA=0x6A8, phtWV=2; count returns to 0 the cycle after.
- Saturation filter: prev=3 with taken=1, then prev=0 with taken=0. No phtWE and count stays 0. Non-conditional branch with prev=1: also nothing enqueued.
- Read blocking and order: hold phtReadEn=1 and issue 5 distinct updates. count=5, phtWE=0 throughout. Release phtReadEn: 5 consecutive phtWE cycles in original order, then count=0.
- Overflow: phtReadEn=1, push 33 updates. The 33rd drops, dropPulse=1 for one cycle, queueFull=1, count=32. Drained contents match the first 32 updates.
- Full with concurrent drain: count=32, phtReadEn=0 and a new update in the same cycle. Accepted, no drop, count stays 32, and the new entry drains last.
- Reset mid-operation: with count=10, assert rst asynchronously (between edges). phtWE=0 and count=0 immediately. After release, the next update drains correctly with pointers wrapped from 0.

Source files
------------

// File: rtl/pht_update_queue_pkg.sv
// Fetch-unit PHT update types, widths and the gshare/counter helpers.
// Shared by the update queue, its interface and the bench.
package pht_update_queue_pkg;

  localparam int PHT_QUEUE_SIZE = 32;
  localparam int PHT_ENTRY_NUM  = 2048;
  localparam int PHT_IW         = $clog2(PHT_ENTRY_NUM);
  localparam int GHIST_WIDTH    = 10;
  localparam int PC_WIDTH       = 32;
  localparam int PHT_QUEUE_CW   = $clog2(PHT_QUEUE_SIZE) + 1;

  typedef logic [$clog2(PHT_QUEUE_SIZE)-1:0] PhtQueuePointerPath;
  typedef logic [PHT_QUEUE_CW-1:0]           PhtQueueCountPath;
  typedef logic [PHT_IW-1:0]                 PhtIndexPath;

  typedef struct packed {
    PhtIndexPath index;
    logic [1:0]  value;
  } PhtQueueEntry;

  // History is aligned to the top of the index so short histories hash the high PC bits.
  function automatic PhtIndexPath ToPHT_IndexByGShare(
    input logic [PC_WIDTH-1:0]    pc,
    input logic [GHIST_WIDTH-1:0] history
  );
    PhtIndexPath hist_aligned;
    hist_aligned = PhtIndexPath'(history) << (PHT_IW - GHIST_WIDTH);
    return pc[PHT_IW+1:2] ^ hist_aligned;
  endfunction

  function automatic logic [1:0] SatCounterUpdate(input logic [1:0] prev, input logic taken);
    if (taken) return (prev == 2'd3) ? 2'd3 : prev + 2'd1;
    else       return (prev == 2'd0) ? 2'd0 : prev - 2'd1;
  endfunction

endpackage

// File: rtl/pht_update_queue_if.sv
// Branch-result input bundle and PHT write-port bundle of the update queue.
// master drives branch results and the fetch read grant; slave is the queue.
interface pht_update_queue_if;
  import pht_update_queue_pkg::*;

  logic                   brValid;
  logic [PC_WIDTH-1:0]    brAddr;
  logic                   brExecTaken;
  logic                   brIsCondBr;
  logic [GHIST_WIDTH-1:0] brGlobalHistory;
  logic [1:0]             brPhtPrevValue;
  logic                   phtReadEn;

  logic                   phtWE;
  PhtIndexPath            phtWA;
  logic [1:0]             phtWV;
  logic                   queueFull;
  PhtQueueCountPath       queueCount;
  logic                   dropPulse;

  modport master (
    output brValid, brAddr, brExecTaken, brIsCondBr, brGlobalHistory, brPhtPrevValue, phtReadEn,
    input  phtWE, phtWA, phtWV, queueFull, queueCount, dropPulse
  );

  modport slave (
    input  brValid, brAddr, brExecTaken, brIsCondBr, brGlobalHistory, brPhtPrevValue, phtReadEn,
    output phtWE, phtWA, phtWV, queueFull, queueCount, dropPulse
  );

endinterface

// File: rtl/pht_update_fifo.sv
// Generic circular FIFO: 1-cycle push-to-pop latency, head readable combinationally.
// Push refused when full unless a pop happens the same cycle; pop ignored when empty.
module pht_update_fifo #(
  parameter int  DEPTH = 32,
  parameter type T     = logic [7:0]
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_vld_i,
  input  T                         push_dat_i,
  input  logic                     pop_vld_i,
  output T                         pop_dat_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  T              mem_q [DEPTH];

  logic pop_fire;
  logic push_fire;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // A pop frees the slot the push needs, so a full queue still accepts with a concurrent pop.
  assign pop_fire  = pop_vld_i && !empty_o;
  assign push_fire = push_vld_i && (!full_o || pop_fire);

  always_comb begin
    head_d  = pop_fire  ? head_q + AW'(1) : head_q;
    tail_d  = push_fire ? tail_q + AW'(1) : tail_q;
    count_d = count_q + (AW+1)'(push_fire) - (AW+1)'(pop_fire);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_fire) mem_q[tail_q] <= push_dat_i;
  end

  assign pop_dat_o = mem_q[head_q];

endmodule

// File: rtl/pht_update_queue.sv
// Queues 2-bit PHT counter updates from branch resolution; >=1 cycle to phtWE, no bypass.
// Drains only when fetch does not own the PHT port; enqueues arriving while full are dropped.
module pht_update_queue
  import pht_update_queue_pkg::*;
(
  input logic                clk,
  input logic                rst,
  pht_update_queue_if.slave  bus
);

  logic         [1:0] new_val;
  logic               enq_vld;
  logic               deq_vld;
  logic               fifo_full;
  logic               fifo_empty;
  PhtQueueEntry       enq_dat;
  PhtQueueEntry       head_dat;
  PhtQueueCountPath   fifo_count;
  logic               drop_q, drop_d;

  assign new_val = SatCounterUpdate(bus.brPhtPrevValue, bus.brExecTaken);

  // Saturated counters would rewrite the same value, so they never occupy a slot.
  assign enq_vld = bus.brValid && bus.brIsCondBr && (new_val != bus.brPhtPrevValue);
  assign enq_dat = '{index: ToPHT_IndexByGShare(bus.brAddr, bus.brGlobalHistory), value: new_val};
  assign deq_vld = !fifo_empty && !bus.phtReadEn;
  assign drop_d  = enq_vld && fifo_full && !deq_vld;

  pht_update_fifo #(
    .DEPTH (PHT_QUEUE_SIZE),
    .T     (PhtQueueEntry)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_vld_i (enq_vld),
    .push_dat_i (enq_dat),
    .pop_vld_i  (deq_vld),
    .pop_dat_o  (head_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_q <= 1'b0;
    else     drop_q <= drop_d;
  end

  assign bus.phtWE      = deq_vld;
  assign bus.phtWA      = head_dat.index;
  assign bus.phtWV      = head_dat.value;
  assign bus.queueFull  = fifo_full;
  assign bus.queueCount = fifo_count;
  assign bus.dropPulse  = drop_q;

endmodule

// File: tb/tb_pht_update_queue.sv
// Directed bench for pht_update_queue: basic update, saturation, read blocking,
// overflow, full-with-drain and asynchronous reset mid-drain.
module tb_pht_update_queue;
  import pht_update_queue_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  pht_update_queue_if bus ();

  pht_update_queue dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] addr, input logic [9:0] hist,
                       input logic [1:0] prev, input logic taken, input logic cond);
    bus.brValid         = 1'b1;
    bus.brAddr          = addr;
    bus.brGlobalHistory = hist;
    bus.brPhtPrevValue  = prev;
    bus.brExecTaken     = taken;
    bus.brIsCondBr      = cond;
  endtask

  task automatic idle();
    bus.brValid = 1'b0;
  endtask

  // Even slots: prev=1 taken -> 2; odd slots: prev=2 not taken -> 1.
  function automatic logic [1:0] exp_val(input int i);
    return (i % 2 == 0) ? 2'd2 : 2'd1;
  endfunction

  task automatic push_slot(input int i, input int wa);
    drive(32'(wa) << 2, 10'd0, (i % 2 == 0) ? 2'd1 : 2'd2, (i % 2 == 0), 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    bus.brValid = 1'b0;
    bus.brAddr = '0;
    bus.brExecTaken = 1'b0;
    bus.brIsCondBr = 1'b0;
    bus.brGlobalHistory = '0;
    bus.brPhtPrevValue = '0;
    bus.phtReadEn = 1'b0;

    #3;
    check("rst_we",    32'(bus.phtWE), 32'd0);
    check("rst_count", 32'(bus.queueCount), 32'd0);
    check("rst_drop",  32'(bus.dropPulse), 32'd0);
    check("rst_full",  32'(bus.queueFull), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Basic update
    drive(32'h0000_1008, 10'h155, 2'd1, 1'b1, 1'b1);
    #1;
    check("basic_nobypass", 32'(bus.phtWE), 32'd0);
    tick();
    idle();
    #1;
    check("basic_we",    32'(bus.phtWE), 32'd1);
    check("basic_wa",    32'(bus.phtWA), 32'h6A8);
    check("basic_wv",    32'(bus.phtWV), 32'd2);
    check("basic_cnt1",  32'(bus.queueCount), 32'd1);
    tick();
    check("basic_cnt0",  32'(bus.queueCount), 32'd0);
    check("basic_we0",   32'(bus.phtWE), 32'd0);

    // Saturation and non-conditional filtering
    drive(32'h0000_2000, 10'h001, 2'd3, 1'b1, 1'b1);
    tick();
    drive(32'h0000_2004, 10'h002, 2'd0, 1'b0, 1'b1);
    tick();
    drive(32'h0000_2008, 10'h003, 2'd1, 1'b1, 1'b0);
    tick();
    idle();
    #1;
    check("sat_we",  32'(bus.phtWE), 32'd0);
    check("sat_cnt", 32'(bus.queueCount), 32'd0);

    // Read blocking, then in-order drain
    bus.phtReadEn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_slot(i, 16 + i);
      #1;
      check("blk_we", 32'(bus.phtWE), 32'd0);
      tick();
    end
    idle();
    check("blk_cnt5", 32'(bus.queueCount), 32'd5);
    bus.phtReadEn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("ord_we", 32'(bus.phtWE), 32'd1);
      check("ord_wa", 32'(bus.phtWA), 32'(16 + i));
      check("ord_wv", 32'(bus.phtWV), 32'(exp_val(i)));
      tick();
    end
    check("ord_cnt0", 32'(bus.queueCount), 32'd0);
    check("ord_we0",  32'(bus.phtWE), 32'd0);

    // Overflow: 33 pushes while blocked
    bus.phtReadEn = 1'b1;
    for (int i = 0; i < 33; i++) begin
      push_slot(i, i);
      tick();
      if (i == 31) begin
        check("ovf_cnt32",   32'(bus.queueCount), 32'd32);
        check("ovf_full",    32'(bus.queueFull), 32'd1);
        check("ovf_nodrop",  32'(bus.dropPulse), 32'd0);
      end
    end
    check("ovf_drop",      32'(bus.dropPulse), 32'd1);
    check("ovf_cnt_hold",  32'(bus.queueCount), 32'd32);
    check("ovf_full_hold", 32'(bus.queueFull), 32'd1);
    idle();
    tick();
    check("ovf_drop_1cyc", 32'(bus.dropPulse), 32'd0);

    // Full with concurrent drain: the new entry is accepted and drains last
    push_slot(0, 100);
    bus.phtReadEn = 1'b0;
    #1;
    check("fd_we", 32'(bus.phtWE), 32'd1);
    check("fd_wa", 32'(bus.phtWA), 32'd0);
    check("fd_wv", 32'(bus.phtWV), 32'(exp_val(0)));
    tick();
    idle();
    check("fd_nodrop", 32'(bus.dropPulse), 32'd0);
    check("fd_cnt32",  32'(bus.queueCount), 32'd32);
    for (int j = 1; j <= 32; j++) begin
      #1;
      check("fd_drain_we", 32'(bus.phtWE), 32'd1);
      check("fd_drain_wa", 32'(bus.phtWA), (j < 32) ? 32'(j) : 32'd100);
      check("fd_drain_wv", 32'(bus.phtWV), (j < 32) ? 32'(exp_val(j)) : 32'd2);
      tick();
    end
    check("fd_cnt0", 32'(bus.queueCount), 32'd0);

    // Asynchronous reset mid-drain
    bus.phtReadEn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_slot(i, 200 + i);
      tick();
    end
    idle();
    check("rm_cnt10", 32'(bus.queueCount), 32'd10);
    bus.phtReadEn = 1'b0;
    #1;
    check("rm_we_pre", 32'(bus.phtWE), 32'd1);
    check("rm_wa_pre", 32'(bus.phtWA), 32'd200);
    #1;
    rst = 1'b1;
    #1;
    check("rm_we",   32'(bus.phtWE), 32'd0);
    check("rm_cnt",  32'(bus.queueCount), 32'd0);
    check("rm_drop", 32'(bus.dropPulse), 32'd0);
    tick();
    rst = 1'b0;
    drive(32'h0000_1008, 10'h155, 2'd2, 1'b0, 1'b1);
    tick();
    idle();
    #1;
    check("post_we",   32'(bus.phtWE), 32'd1);
    check("post_wa",   32'(bus.phtWA), 32'h6A8);
    check("post_wv",   32'(bus.phtWV), 32'd1);
    check("post_cnt1", 32'(bus.queueCount), 32'd1);
    tick();
    check("post_cnt0", 32'(bus.queueCount), 32'd0);
    check("post_we0",  32'(bus.phtWE), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
